// File: rtl/jtframe_romrq_arbiter.sv
// jtframe_romrq_arbiter: round-robin share of one SDRAM bank read port among cached ROM slots
module jtframe_romrq_arbiter #(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 16
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_downloading,
    input  logic [SLOTS-1:0]    i_slot_cs,
    input  logic [SLOTS*AW-1:0] i_slot_addr,
    output logic [SLOTS-1:0]    o_slot_ok,
    output logic [SLOTS*DW-1:0] o_slot_dout,
    output logic [AW-1:0]       o_ba_addr,
    output logic                o_ba_rd,
    input  logic                i_ba_ack,
    input  logic                i_ba_rdy,
    input  logic [DW-1:0]       i_data_read,
    output logic                o_busy
);
    localparam int PW = $clog2(SLOTS);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t          r_state, w_next;
    logic [SLOTS-1:0] r_valid, w_ok, w_pending;
    logic [AW-1:0]   r_cache_addr [SLOTS];
    logic [DW-1:0]   r_dout [SLOTS];
    logic [PW-1:0]   r_rr, r_gnt, w_sel, w_gnt_inc;
    logic            w_start, w_done;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign w_ok[i] = i_slot_cs[i] && r_valid[i] && i_slot_addr[i*AW +: AW] == r_cache_addr[i];
        assign o_slot_dout[i*DW +: DW] = r_dout[i];
    end

    assign o_slot_ok = w_ok;
    assign w_pending = i_slot_cs & ~w_ok;
    assign o_busy    = r_state != IDLE;
    assign w_start   = r_state == IDLE && !i_downloading && |w_pending;
    assign w_done    = i_ba_rdy && (r_state == WAIT || (r_state == REQ && i_ba_ack));
    assign w_gnt_inc = r_gnt == PW'(SLOTS-1) ? '0 : r_gnt + 1'b1;

    // scan downwards so the pending slot closest to rr wins
    always_comb begin
        w_sel = r_rr;
        for (int k = SLOTS-1; k >= 0; k--) begin
            if (w_pending[(int'(r_rr) + k) % SLOTS]) w_sel = PW'((int'(r_rr) + k) % SLOTS);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? REQ : IDLE;
            REQ:     w_next = i_ba_ack ? (i_ba_rdy ? IDLE : WAIT) : REQ;
            default: w_next = i_ba_rdy ? IDLE : WAIT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_valid   <= '0;
            o_ba_rd   <= 1'b0;
            o_ba_addr <= '0;
            r_rr      <= '0;
            r_gnt     <= '0;
            for (int k = 0; k < SLOTS; k++) begin
                r_cache_addr[k] <= '0;
                r_dout[k]       <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_gnt               <= w_sel;
                o_ba_addr           <= i_slot_addr[w_sel*AW +: AW];
                r_cache_addr[w_sel] <= i_slot_addr[w_sel*AW +: AW];
                r_valid[w_sel]      <= 1'b0;
                o_ba_rd             <= 1'b1;
            end
            if (r_state == REQ && i_ba_ack) o_ba_rd <= 1'b0;
            if (w_done) begin
                r_dout[r_gnt]  <= i_data_read;
                r_valid[r_gnt] <= 1'b1;
                r_rr           <= w_gnt_inc;
            end
            // a download invalidates everything, including a fill landing this cycle
            if (i_downloading && (r_state == IDLE || w_done)) r_valid <= '0;
        end
    end
endmodule

// File: tb/tb_jtframe_romrq_arbiter.sv
// tb_jtframe_romrq_arbiter: directed scoreboard bench for the ROM request arbiter
module tb_jtframe_romrq_arbiter;
    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_cs = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic [AW-1:0]       ba_addr;
    logic                ba_rd;
    logic                ba_ack = 1'b0;
    logic                ba_rdy = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                busy;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] sb[$];

    jtframe_romrq_arbiter #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_downloading(downloading),
        .i_slot_cs(slot_cs), .i_slot_addr(slot_addr),
        .o_slot_ok(slot_ok), .o_slot_dout(slot_dout),
        .o_ba_addr(ba_addr), .o_ba_rd(ba_rd),
        .i_ba_ack(ba_ack), .i_ba_rdy(ba_rdy),
        .i_data_read(data_read), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [31:0] dout(input int i);
        return 32'(slot_dout[i*DW +: DW]);
    endfunction

    task automatic wait_rd(output int n);
        logic [AW-1:0] e;
        n = 0;
        while (!ba_rd && n < 20) begin
            tick();
            n++;
        end
        chk("ba_rd_seen", 32'(ba_rd), 1);
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk("ba_addr", 32'(ba_addr), 32'(e));
    endtask

    task automatic grant_ack(input int d, output int n);
        logic [AW-1:0] a;
        wait_rd(n);
        a = ba_addr;
        repeat (d) begin
            tick();
            chk("ba_rd_hold", 32'(ba_rd), 1);
            chk("ba_addr_hold", 32'(ba_addr), 32'(a));
        end
        ba_ack = 1'b1;
        tick();
        ba_ack = 1'b0;
        chk("ba_rd_drop", 32'(ba_rd), 0);
        chk("busy_wait", 32'(busy), 1);
    endtask

    task automatic give_rdy(input int d, input logic [DW-1:0] v);
        repeat (d-1) tick();
        ba_rdy = 1'b1;
        data_read = v;
        tick();
        ba_rdy = 1'b0;
    endtask

    task automatic serve(input int ad, input int rd, input logic [DW-1:0] v);
        int n;
        grant_ack(ad, n);
        give_rdy(rd, v);
    endtask

    initial begin
        int n;
        // reset state
        tick();
        tick();
        chk("rst_ba_rd", 32'(ba_rd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ba_addr", 32'(ba_addr), 0);
        chk("rst_ok", 32'(slot_ok), 0);
        chk("rst_dout", 32'(|slot_dout), 0);
        rst_n = 1'b1;
        tick();
        // single miss then repeated hit
        slot_cs = 4'b0001;
        set_addr(0, 22'h001234);
        sb.push_back(22'h001234);
        grant_ack(3, n);
        chk("rd_latency", 32'(n), 1);
        give_rdy(4, 16'hBEEF);
        chk("t1_ok", 32'(slot_ok), 32'h1);
        chk("t1_dout", dout(0), 32'hBEEF);
        chk("t1_busy", 32'(busy), 0);
        repeat (3) begin
            tick();
            chk("t1_hit_no_rd", 32'(ba_rd), 0);
            chk("t1_hit_ok", 32'(slot_ok), 32'h1);
        end
        // all four slots from reset, then slot 0 re-requests
        rst_n = 1'b0;
        slot_cs = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            set_addr(i, 22'h100 + 22'(i));
            sb.push_back(22'h100 + 22'(i));
        end
        slot_cs = 4'b1111;
        serve(1, 2, 16'hA000);
        set_addr(0, 22'h200);
        sb.push_back(22'h200);
        for (int i = 1; i < SLOTS; i++) serve(1, 2, 16'hA000 + 16'(i));
        serve(1, 2, 16'hB000);
        chk("t2_ok", 32'(slot_ok), 32'hF);
        chk("t2_dout0", dout(0), 32'hB000);
        chk("t2_dout1", dout(1), 32'hA001);
        chk("t2_dout3", dout(3), 32'hA003);
        // slot 2 changes address while in flight
        slot_cs = 4'b0100;
        set_addr(2, 22'h10);
        sb.push_back(22'h10);
        grant_ack(1, n);
        set_addr(2, 22'h20);
        sb.push_back(22'h20);
        give_rdy(2, 16'h1010);
        chk("t3_stale_ok", 32'(slot_ok), 0);
        chk("t3_stale_dout", dout(2), 32'h1010);
        serve(1, 2, 16'h2020);
        chk("t3_ok", 32'(slot_ok), 32'h4);
        chk("t3_dout", dout(2), 32'h2020);
        // download starts during REQ
        slot_cs = 4'b0110;
        set_addr(1, 22'h300);
        sb.push_back(22'h300);
        tick();
        downloading = 1'b1;
        grant_ack(2, n);
        give_rdy(2, 16'h3030);
        repeat (4) begin
            tick();
            chk("t4_dl_ok", 32'(slot_ok), 0);
            chk("t4_dl_no_rd", 32'(ba_rd), 0);
            chk("t4_dl_busy", 32'(busy), 0);
        end
        downloading = 1'b0;
        sb.push_back(22'h20);
        sb.push_back(22'h300);
        serve(1, 2, 16'h2222);
        serve(1, 2, 16'h3333);
        chk("t4_ok", 32'(slot_ok), 32'h6);
        chk("t4_dout1", dout(1), 32'h3333);
        chk("t4_dout2", dout(2), 32'h2222);
        // ack and rdy in the same cycle
        slot_cs = 4'b1110;
        set_addr(3, 22'h400);
        sb.push_back(22'h400);
        wait_rd(n);
        ba_ack = 1'b1;
        ba_rdy = 1'b1;
        data_read = 16'h4444;
        tick();
        ba_ack = 1'b0;
        ba_rdy = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ok", 32'(slot_ok), 32'hE);
        chk("t5_dout", dout(3), 32'h4444);
        tick();
        chk("t5_no_rd", 32'(ba_rd), 0);
        // reset while waiting for data
        slot_cs = 4'b1001;
        set_addr(0, 22'h500);
        sb.push_back(22'h500);
        grant_ack(1, n);
        chk("t6_pre_ok", 32'(slot_ok), 32'h8);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rd", 32'(ba_rd), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ok", 32'(slot_ok), 0);
        chk("t6_rst_dout", 32'(|slot_dout), 0);
        tick();
        rst_n = 1'b1;
        sb.push_back(22'h500);
        sb.push_back(22'h400);
        serve(0, 1, 16'h5555);
        serve(0, 1, 16'h6666);
        chk("t6_ok", 32'(slot_ok), 32'h9);
        chk("t6_dout0", dout(0), 32'h5555);
        chk("t6_dout3", dout(3), 32'h6666);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtframe_romrq_arbiter.md
Name: jtframe_romrq_arbiter

Overview:
- Shares one SDRAM bank read port (addr/rd/ack/rdy plus 16-bit data) among SLOTS game-side ROM requesters, using round-robin order.
- Each slot has a one-entry cache (last address and data). Repeated reads of the same address are served without an SDRAM access.
- Sits between game ROM fetch logic and the frame's bank interface, in the clk_rom domain.
- While a ROM download is in progress, no new accesses are issued.

Parameters:
SLOTS, 4, number of requesters (2..8)
AW, 22, SDRAM word address width (matches SDRAMW)
DW, 16, data width

Ports:
clk  in  1  system/SDRAM clock
rst_n  in  1  asynchronous active-low reset
downloading  in  1  ROM download active; blocks new grants
slot_cs  in  SLOTS  per-slot read request (level)
slot_addr  in  SLOTS*AW  per-slot address, slot i at [i*AW +: AW]
slot_ok  out  SLOTS  slot data valid for the current slot_addr
slot_dout  out  SLOTS*DW  per-slot data, slot i at [i*DW +: DW]
ba_addr  out  AW  address to SDRAM bank
ba_rd  out  1  bank read request
ba_ack  in  1  bank accepted request
ba_rdy  in  1  bank read data valid (one-cycle pulse)
data_read  in  DW  SDRAM read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n=0) clears the following immediately:
  - state=IDLE, ba_rd=0, ba_addr=0, busy=0
  - all cache valid bits=0, cached addresses=0, slot_dout=0
  - round-robin pointer rr=0
- slot_ok[i] is combinational: slot_cs[i] && valid[i] && slot_addr[i]==cache_addr[i].
- pending[i] = slot_cs[i] && !slot_ok[i].
- States:
  - IDLE:
    - If downloading=1, stay in IDLE.
    - Else, if any pending: pick the first pending slot searching rr, rr+1, ..., wrapping modulo SLOTS.
    - Register gnt=that slot, ba_addr=slot_addr[gnt], cache_addr[gnt]=slot_addr[gnt], valid[gnt]=0. Set ba_rd=1 and go to REQ.
    - Grant decision takes one cycle: ba_rd rises the cycle after pending is seen.
  - REQ:
    - Hold ba_rd=1 and ba_addr stable until ba_ack=1.
    - On ack: ba_rd=0 and go to WAIT.
    - If ba_ack and ba_rdy arrive in the same cycle, complete as in WAIT and go to IDLE.
  - WAIT:
    - On ba_rdy: slot_dout[gnt]=data_read, valid[gnt]=1, rr=(gnt+1) mod SLOTS, go to IDLE.
    - slot_ok[gnt] rises the cycle after ba_rdy, provided the slot address still matches.
- ba_rdy is ignored in IDLE. ba_ack is ignored outside REQ.
- If slot_addr changes while that slot is in flight:
  - The fetched data is still stored against the issued address.
  - The mismatch keeps slot_ok=0, and the slot re-requests on a later grant.
- If slot_cs drops while in flight, the transaction completes and the cache is filled. No abort is possible.
- If downloading rises mid-transaction, the current transaction completes normally.
  - The cycle the arbiter returns to IDLE (or at once, if already IDLE with downloading=1), all valid bits are cleared.
  - The arbiter then stays in IDLE until downloading=0.
  - Clearing continues every cycle downloading=1, so stale ROM data is never reported after a download.
- Hit path never touches SDRAM: a slot with a cache hit gets slot_ok=1 with zero added latency and does not affect rr.
- Fairness: after slot i is served, slot i has lowest priority. Under full load each slot waits at most SLOTS-1 transactions.
- busy=1 exactly when state is REQ or WAIT.

Test Plan:
- Single miss, slot 0, addr 0x001234:
  - ba_rd rises 1 cycle after cs and holds until ack (ack 3 cycles later); rdy 4 cycles after ack with data 0xBEEF.
  - Required: slot_dout[0]=0xBEEF, slot_ok[0]=1 one cycle after rdy.
  - A repeat read of the same address gives ok with ba_rd staying 0.
- All 4 slots request at once from reset (rr=0):
  - Grant order is 0,1,2,3.
  - Slot 0 re-requests a new addr after its service: order continues 1,2,3,0 and no slot is starved.
- Slot 2 changes address from 0x10 to 0x20 during WAIT:
  - Data for 0x10 is stored, slot_ok[2] stays 0.
  - A second transaction is issued for 0x20 and ok rises after its rdy.
- downloading asserted during REQ:
  - The transaction completes on ack/rdy; then all slot_ok go 0 and ba_rd stays 0 while downloading=1.
  - After downloading=0, the previously cached address re-fetches from SDRAM.
- ba_ack and ba_rdy in the same cycle: state returns to IDLE, data is captured, and ok rises next cycle.
- rst_n pulled low in WAIT: ba_rd, busy, slot_ok and slot_dout are 0 immediately. After release, a pending cs starts a new grant at slot 0.
